// File: rtl/codec_pkg.sv
// codec_pkg: shared widths, control states and the GF(2^8) multiply for the 128-bit codec.
package codec_pkg;
  localparam int DATA_W = 128;
  localparam int COEF_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  // GF(2^8) product reduced by x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
endpackage

// File: rtl/codec_128bit.sv
// codec_128bit: bytewise c1*d1 + c2*d2 over GF(2^8), registered LAT cycles deep.
module codec_128bit import codec_pkg::*; #(
  parameter int LAT = 1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [COEF_W-1:0] iCoefficient1,
  input  logic [COEF_W-1:0] iCoefficient2,
  input  logic [DATA_W-1:0] iData1,
  input  logic [DATA_W-1:0] iData2,
  output logic [DATA_W-1:0] oOutput
);
  logic [DATA_W-1:0] mix;
  logic [DATA_W-1:0] pipe_q [LAT];
  always_comb begin
    mix = '0;
    for (int b = 0; b < DATA_W / 8; b++)
      mix[8*b +: 8] = gf_mul(iCoefficient1, iData1[8*b +: 8]) ^ gf_mul(iCoefficient2, iData2[8*b +: 8]);
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) pipe_q <= '{default: '0};
    else begin
      pipe_q[0] <= mix;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  assign oOutput = pipe_q[LAT-1];
endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO, power-of-2 depth, async active-low reset.
module stream_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic wr_en, rd_en;
  assign wr_en = push_i && !full_o;
  assign rd_en = pop_i && !empty_o;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = mem_q[rd_q];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(wr_en);
      rd_q <= rd_q + AW'(rd_en);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  always_ff @(posedge clk_i)
    if (wr_en) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/codec_stream_ctrl.sv
// codec_stream_ctrl: pairs two source streams, codes them with per-packet coefficients
// and buffers results for a backpressured consumer without ever dropping one.
module codec_stream_ctrl import codec_pkg::*; #(
  parameter int IN_DEPTH = 4,
  parameter int OUT_DEPTH = 4,
  parameter int CODEC_LAT = 1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iCoefLoad,
  input  logic [COEF_W-1:0] iCoefficient1,
  input  logic [COEF_W-1:0] iCoefficient2,
  input  logic              iValid1,
  input  logic              iValid2,
  input  logic [DATA_W-1:0] iData1,
  input  logic [DATA_W-1:0] iData2,
  input  logic              iLast1,
  input  logic              iLast2,
  output logic              oReady1,
  output logic              oReady2,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic              oLast,
  input  logic              iReady,
  output logic              oBusy,
  output logic              oErrLast
);
  localparam int CW = $clog2(OUT_DEPTH + CODEC_LAT + 2) + 1;
  state_t state_q, state_d;
  logic [COEF_W-1:0] c1_q, c2_q;
  logic [DATA_W:0] h1, h2, out_head;
  logic [DATA_W-1:0] iss_d1_q, iss_d2_q, codec_out;
  logic [$clog2(OUT_DEPTH):0] out_cnt;
  logic [CODEC_LAT-1:0] trk_v_q, trk_l_q;
  logic [CW-1:0] inflight;
  logic full1, full2, empty1, empty2, out_empty;
  logic iss_v_q, iss_last_q, err_q, issue, pair_last;
  stream_fifo #(.W(DATA_W + 1), .DEPTH(IN_DEPTH)) u_in1 (
    .clk_i(iCLK), .rst_ni(iRST_N), .push_i(iValid1 && oReady1), .pop_i(issue),
    .din_i({iLast1, iData1}), .dout_o(h1), .full_o(full1), .empty_o(empty1), .count_o()
  );
  stream_fifo #(.W(DATA_W + 1), .DEPTH(IN_DEPTH)) u_in2 (
    .clk_i(iCLK), .rst_ni(iRST_N), .push_i(iValid2 && oReady2), .pop_i(issue),
    .din_i({iLast2, iData2}), .dout_o(h2), .full_o(full2), .empty_o(empty2), .count_o()
  );
  stream_fifo #(.W(DATA_W + 1), .DEPTH(OUT_DEPTH)) u_out (
    .clk_i(iCLK), .rst_ni(iRST_N), .push_i(trk_v_q[CODEC_LAT-1]), .pop_i(oValid && iReady),
    .din_i({trk_l_q[CODEC_LAT-1], codec_out}), .dout_o(out_head), .full_o(), .empty_o(out_empty),
    .count_o(out_cnt)
  );
  codec_128bit #(.LAT(CODEC_LAT)) u_codec (
    .iCLK(iCLK), .iRST_N(iRST_N), .iCoefficient1(c1_q), .iCoefficient2(c2_q),
    .iData1(iss_d1_q), .iData2(iss_d2_q), .oOutput(codec_out)
  );
  // Results still travelling through the issue register and codec hold an output slot.
  always_comb begin
    inflight = CW'(iss_v_q);
    for (int i = 0; i < CODEC_LAT; i++) inflight = inflight + CW'(trk_v_q[i]);
  end
  assign pair_last = h1[DATA_W] | h2[DATA_W];
  assign issue = state_q == RUN && !empty1 && !empty2 && CW'(out_cnt) + inflight < CW'(OUT_DEPTH);
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (iCoefLoad ? RUN : IDLE) :
              state_q == RUN ? (issue && pair_last ? DRAIN : RUN) :
              (inflight == '0 && out_empty ? IDLE : DRAIN);
  always_comb begin
    oReady1 = state_q == RUN && !full1;
    oReady2 = state_q == RUN && !full2;
    oBusy = state_q != IDLE;
    oValid = !out_empty;
    oLast = oValid && out_head[DATA_W];
    oData = oValid ? out_head[DATA_W-1:0] : '0;
    oErrLast = err_q;
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      c1_q <= '0;
      c2_q <= '0;
      iss_v_q <= 1'b0;
      iss_last_q <= 1'b0;
      trk_v_q <= '0;
      trk_l_q <= '0;
      err_q <= 1'b0;
    end else begin
      c1_q <= state_q == IDLE && iCoefLoad ? iCoefficient1 : c1_q;
      c2_q <= state_q == IDLE && iCoefLoad ? iCoefficient2 : c2_q;
      iss_v_q <= issue;
      iss_last_q <= pair_last;
      trk_v_q <= (trk_v_q << 1) | CODEC_LAT'(iss_v_q);
      trk_l_q <= (trk_l_q << 1) | CODEC_LAT'(iss_last_q);
      err_q <= err_q | (issue && h1[DATA_W] != h2[DATA_W]);
    end
  always_ff @(posedge iCLK)
    if (issue) begin
      iss_d1_q <= h1[DATA_W-1:0];
      iss_d2_q <= h2[DATA_W-1:0];
    end
endmodule
